// File: rtl/izh_pkg.sv
// ---------------------------------------------------------------------------
// izh_pkg
// Shared definitions for the Izhikevich spike monitor:
//   - V_W          : membrane-voltage sample width (2.6 signed fixed point)
//   - TH_HI_DEF    : default spike threshold (30 mV in 2.6 format)
//   - TH_LO_DEF    : default re-arm threshold
//   - ISI_W_DEF    : default ISI field width
//   - izh_state_t  : hysteresis detector state
//   - izh_event_t  : event record layout at the default ISI width
// ---------------------------------------------------------------------------
package izh_pkg;

   localparam int V_W       = 8;
   localparam int ISI_W_DEF = 12;

   localparam logic signed [V_W-1:0] TH_HI_DEF = 8'sd19;
   localparam logic signed [V_W-1:0] TH_LO_DEF = 8'sd0;

   typedef enum logic {
      BELOW = 1'b0,
      ABOVE = 1'b1
   } izh_state_t;

   // Field order matches the ev_data bus: {first, sat, isi}.
   typedef struct packed {
      logic                 first;
      logic                 sat;
      logic [ISI_W_DEF-1:0] isi;
   } izh_event_t;

endpackage

// File: rtl/izh_event_fifo.sv
// ---------------------------------------------------------------------------
// izh_event_fifo
// Synchronous first-word-fall-through FIFO for spike events.
//   clk, rst : clock and synchronous active-high reset (pointers only)
//   push     : write din (accepted when not full, or when full with a pop)
//   pop      : remove head entry (ignored when empty)
//   din      : entry to write
//   dout     : head entry, forced to zero while empty
//   full     : DEPTH entries held
//   empty    : no entries held
// ---------------------------------------------------------------------------
module izh_event_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, a same-cycle pop frees the slot being overwritten.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/izh_spike_monitor.sv
// ---------------------------------------------------------------------------
// izh_spike_monitor
// Watches the neuron core's membrane voltage, detects spikes with hysteresis,
// measures the inter-spike interval in enabled samples and queues events.
//   clk, rst    : clock and synchronous active-high reset
//   sample_en   : v_in is valid this cycle
//   v_in        : signed membrane voltage, 2.6 fixed point
//   clr         : clears spike_count and overflow
//   spike_pulse : one-cycle strobe, cycle after the spike sample
//   ev_valid    : event FIFO non-empty
//   ev_ready    : consumer accepts head event
//   ev_data     : head event {first, sat, isi}
//   spike_count : wrapping count of detected spikes
//   overflow    : sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module izh_spike_monitor
   import izh_pkg::*;
#(
   parameter int                      ISI_W      = ISI_W_DEF,
   parameter int                      FIFO_DEPTH = 4,
   parameter logic signed [V_W-1:0]   TH_HI      = TH_HI_DEF,
   parameter logic signed [V_W-1:0]   TH_LO      = TH_LO_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_en,
   input  logic signed [V_W-1:0] v_in,
   input  logic                  clr,
   output logic                  spike_pulse,
   output logic                  ev_valid,
   input  logic                  ev_ready,
   output logic [ISI_W+1:0]      ev_data,
   output logic [15:0]           spike_count,
   output logic                  overflow
);

   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   izh_state_t       state;
   izh_state_t       state_nxt;
   logic [ISI_W-1:0] isi_cnt;
   logic [ISI_W-1:0] isi_cap;
   logic             first_pending;
   logic             spike_p0;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ISI_W+1:0] ev_din;

   function automatic logic [ISI_W-1:0] sat_inc(input logic [ISI_W-1:0] x);
      return (x == ISI_MAX) ? x : x + 1'b1;
   endfunction

   // Hysteresis detector: only the BELOW->ABOVE crossing is a spike.
   always_comb begin
      state_nxt = state;
      spike_p0  = 1'b0;
      if (sample_en) begin
         case (state)
            BELOW: if (v_in > TH_HI) begin
               state_nxt = ABOVE;
               spike_p0  = 1'b1;
            end
            ABOVE: if (v_in < TH_LO) state_nxt = BELOW;
            default: state_nxt = BELOW;
         endcase
      end
   end

   assign isi_cap  = sat_inc(isi_cnt);
   assign ev_din   = {first_pending, (isi_cap == ISI_MAX), isi_cap};
   assign ev_valid = !fifo_empty;
   assign pop      = ev_valid && ev_ready;
   assign drop     = spike_p0 && fifo_full && !pop;

   // Stage p0 -> registered outputs and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BELOW;
         isi_cnt       <= '0;
         first_pending <= 1'b1;
         spike_pulse   <= 1'b0;
         spike_count   <= '0;
         overflow      <= 1'b0;
      end else begin
         state       <= state_nxt;
         spike_pulse <= spike_p0;
         if (sample_en) isi_cnt <= spike_p0 ? '0 : isi_cap;
         if (spike_p0)  first_pending <= 1'b0;
         // A spike coinciding with clr is counted into the fresh count.
         if (clr) begin
            spike_count <= spike_p0 ? 16'd1 : 16'd0;
            overflow    <= drop;
         end else begin
            if (spike_p0) spike_count <= spike_count + 16'd1;
            if (drop)     overflow    <= 1'b1;
         end
      end
   end

   izh_event_fifo #(
      .WIDTH (ISI_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (spike_p0),
      .pop   (pop),
      .din   (ev_din),
      .dout  (ev_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_izh_spike_monitor.sv
module tb_izh_spike_monitor;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_en = 1'b0;
   logic signed [7:0] v_in = '0;
   logic              clr = 1'b0;
   logic              ev_ready = 1'b0;

   logic        spike_pulse, ev_valid, overflow;
   logic [13:0] ev_data;
   logic [15:0] spike_count;

   logic        spike_pulse4, ev_valid4, overflow4;
   logic [5:0]  ev_data4;
   logic [15:0] spike_count4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   izh_spike_monitor u_dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .v_in(v_in), .clr(clr),
      .spike_pulse(spike_pulse), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_data(ev_data), .spike_count(spike_count), .overflow(overflow)
   );

   izh_spike_monitor #(.ISI_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .sample_en(sample_en), .v_in(v_in), .clr(clr),
      .spike_pulse(spike_pulse4), .ev_valid(ev_valid4), .ev_ready(ev_ready),
      .ev_data(ev_data4), .spike_count(spike_count4), .overflow(overflow4)
   );

   // Apply one cycle of inputs at the falling edge, return 1 ns after the rising edge.
   task automatic step(input logic en, input logic signed [7:0] v, input logic rdy, input logic c);
      @(negedge clk);
      sample_en = en;
      v_in      = v;
      ev_ready  = rdy;
      clr       = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; sample_en = 1'b0; ev_ready = 1'b0; clr = 1'b0; v_in = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (spike_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got=%b want=0", spike_pulse); end
      n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", ev_valid); end
      n_cmp++; if (ev_data !== 14'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", ev_data); end
      n_cmp++; if (spike_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", spike_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      release_reset();
   endtask

   task automatic test_first_spike();
      for (int i = 0; i < 9; i++) step(1'b1, -8'sd45, 1'b0, 1'b0);
      n_cmp++; if (spike_pulse !== 1'b0) begin n_bad++; $display("FAIL pre_spike_pulse got=%b want=0", spike_pulse); end
      step(1'b1, 8'sd25, 1'b0, 1'b0);
      n_cmp++; if (spike_pulse !== 1'b1) begin n_bad++; $display("FAIL spike1_pulse got=%b want=1", spike_pulse); end
      n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL spike1_valid got=%b want=1", ev_valid); end
      n_cmp++; if (ev_data !== 14'h200A) begin n_bad++; $display("FAIL spike1_data got=%h want=200a", ev_data); end
      n_cmp++; if (spike_count !== 16'd1) begin n_bad++; $display("FAIL spike1_count got=%0d want=1", spike_count); end
   endtask

   task automatic test_hysteresis();
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'sd25, 1'b0, 1'b0);
         if (spike_pulse) pulses++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, -8'sd5, 1'b0, 1'b0);
         if (spike_pulse) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL hyst_no_pulse got=%0d want=0", pulses); end
      step(1'b1, 8'sd25, 1'b0, 1'b0);
      n_cmp++; if (spike_pulse !== 1'b1) begin n_bad++; $display("FAIL spike2_pulse got=%b want=1", spike_pulse); end
      n_cmp++; if (spike_count !== 16'd2) begin n_bad++; $display("FAIL spike2_count got=%0d want=2", spike_count); end
      n_cmp++; if (ev_data !== 14'h200A) begin n_bad++; $display("FAIL head_stable got=%h want=200a", ev_data); end
      step(1'b0, 8'sd0, 1'b1, 1'b0);
      n_cmp++; if (ev_data !== 14'h0008) begin n_bad++; $display("FAIL spike2_data got=%h want=0008", ev_data); end
      step(1'b0, 8'sd0, 1'b1, 1'b0);
      n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL drained_valid got=%b want=0", ev_valid); end
   endtask

   task automatic test_overflow();
      int popped = 0;
      do_reset();
      release_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'sd25, 1'b0, 1'b0);
         if (i == 3) begin
            n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_4 got=%b want=0", overflow); end
         end
         step(1'b1, -8'sd5, 1'b0, 1'b0);
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
      n_cmp++; if (spike_count !== 16'd5) begin n_bad++; $display("FAIL ovf_count got=%0d want=5", spike_count); end
      n_cmp++; if (ev_data !== 14'h2001) begin n_bad++; $display("FAIL ovf_head got=%h want=2001", ev_data); end
      // Sixth spike lands in the same cycle as a pop of the full FIFO.
      step(1'b1, 8'sd25, 1'b1, 1'b0);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got=%b want=1", overflow); end
      n_cmp++; if (spike_count !== 16'd6) begin n_bad++; $display("FAIL ovf_count6 got=%0d want=6", spike_count); end
      n_cmp++; if (ev_data !== 14'h0002) begin n_bad++; $display("FAIL ovf_head2 got=%h want=0002", ev_data); end
      for (int i = 0; i < 6; i++) begin
         if (ev_valid) begin
            popped++;
            n_cmp++; if (ev_data !== 14'h0002) begin n_bad++; $display("FAIL drain_data got=%h want=0002", ev_data); end
         end
         step(1'b0, 8'sd0, 1'b1, 1'b0);
      end
      n_cmp++; if (popped !== 4) begin n_bad++; $display("FAIL drain_entries got=%0d want=4", popped); end
   endtask

   task automatic test_saturation();
      do_reset();
      release_reset();
      for (int i = 0; i < 20; i++) step(1'b1, -8'sd45, 1'b0, 1'b0);
      step(1'b1, 8'sd25, 1'b0, 1'b0);
      n_cmp++; if (ev_data4 !== 6'h3F) begin n_bad++; $display("FAIL sat4_data got=%h want=3f", ev_data4); end
      n_cmp++; if (ev_valid4 !== 1'b1) begin n_bad++; $display("FAIL sat4_valid got=%b want=1", ev_valid4); end
      n_cmp++; if (spike_pulse4 !== 1'b1) begin n_bad++; $display("FAIL sat4_pulse got=%b want=1", spike_pulse4); end
      n_cmp++; if ({overflow4, spike_count4} !== 17'd1) begin n_bad++; $display("FAIL sat4_cnt got=%h want=00001", {overflow4, spike_count4}); end
      n_cmp++; if (ev_data !== 14'h2015) begin n_bad++; $display("FAIL nosat12_data got=%h want=2015", ev_data); end
   endtask

   task automatic test_sample_en_freeze();
      int pulses = 0;
      do_reset();
      release_reset();
      for (int i = 0; i < 3; i++) step(1'b1, -8'sd45, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 8'sd25, 1'b0, 1'b0);
         if (spike_pulse) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL frozen_pulse got=%0d want=0", pulses); end
      for (int i = 0; i < 2; i++) step(1'b1, -8'sd45, 1'b0, 1'b0);
      step(1'b1, 8'sd25, 1'b0, 1'b0);
      n_cmp++; if (ev_data !== 14'h2006) begin n_bad++; $display("FAIL frozen_isi got=%h want=2006", ev_data); end
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, -8'sd5, 1'b0, 1'b0);
         step(1'b1, 8'sd25, 1'b0, 1'b0);
      end
      n_cmp++; if (spike_count !== 16'd3) begin n_bad++; $display("FAIL pre_rst_count got=%0d want=3", spike_count); end
      do_reset();
      n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush got=%b want=0", ev_valid); end
      release_reset();
      step(1'b1, -8'sd45, 1'b0, 1'b0);
      step(1'b1, 8'sd25, 1'b0, 1'b0);
      n_cmp++; if (ev_data !== 14'h2002) begin n_bad++; $display("FAIL rst_first got=%h want=2002", ev_data); end
   endtask

   task automatic test_clr();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, -8'sd5, 1'b0, 1'b0);
         step(1'b1, 8'sd25, 1'b0, 1'b0);
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ovf got=%b want=1", overflow); end
      step(1'b0, 8'sd0, 1'b1, 1'b0);
      step(1'b1, -8'sd5, 1'b0, 1'b0);
      step(1'b1, 8'sd25, 1'b0, 1'b1);
      n_cmp++; if (spike_count !== 16'd1) begin n_bad++; $display("FAIL clr_spike_count got=%0d want=1", spike_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got=%b want=0", overflow); end
      n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL clr_fifo_kept got=%b want=1", ev_valid); end
      step(1'b1, -8'sd5, 1'b0, 1'b1);
      n_cmp++; if (spike_count !== 16'd0) begin n_bad++; $display("FAIL clr_only_count got=%0d want=0", spike_count); end
   endtask

   initial begin
      test_reset();
      test_first_spike();
      test_hysteresis();
      test_overflow();
      test_saturation();
      test_sample_en_freeze();
      test_rst_mid();
      test_clr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
